// File: rtl/autoconfig_host.sv
// Zorro II Autoconfig enumerator: walks the $E80000 chain as a 68000 bus
// initiator and assigns FastRAM windows inside $200000-$9FFFFF.
module autoconfig_host #(
    parameter int TIMEOUT  = 64,
    parameter int MAX_ITER = 16
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [22:0] ADDR,
    output logic [3:0]  DBUS_OUT,
    output logic        DBUS_OE,
    input  logic [3:0]  DBUS_IN,
    output logic        ASn,
    output logic        UDSn,
    output logic        LDSn,
    output logic        RWn,
    input  logic        DTACKn,
    output logic        CFGOUTn,
    output logic [7:0]  mem_map,
    output logic [3:0]  boards
);

    localparam logic [22:0] A_TYPE = 23'h740000;
    localparam logic [22:0] A_SIZE = 23'h740001;
    localparam logic [22:0] A_HI   = 23'h740024;
    localparam logic [22:0] A_LO   = 23'h740025;
    localparam logic [22:0] A_SHUT = 23'h740026;

    localparam int WW = $clog2(TIMEOUT + 1);
    localparam int IW = $clog2(MAX_ITER + 1);
    localparam logic [WW-1:0] W_LAST   = WW'(TIMEOUT - 1);
    localparam logic [IW-1:0] ITER_MAX = IW'(MAX_ITER);

    typedef enum logic [2:0] {
        B_IDLE, B_S0, B_S2, B_S4, B_WAIT, B_S7, B_S8
    } bstate_t;

    typedef enum logic [3:0] {
        E_IDLE, E_RD_TYPE, E_RD_SIZE, E_DECIDE, E_WR_LO,
        E_WR_HI, E_SHUTUP, E_GAP, E_DONE
    } estate_t;

    bstate_t bst;
    estate_t est;

    logic          req;
    logic          req_wr;
    logic [22:0]   req_addr;
    logic [3:0]    req_data;
    logic          bus_done;
    logic [3:0]    rdata;
    logic          nack;
    logic          wr_cyc;
    logic [WW-1:0] wcnt;
    logic          dtack_q1;
    logic          dtack_s;

    logic          issued;
    logic          gap;
    logic          is_mem_r;
    logic [2:0]    size_r;
    logic [3:0]    nf;
    logic [3:0]    base_r;
    logic [3:0]    sz_r;
    logic [IW-1:0] iter;
    logic [IW-1:0] iter_nx;

    logic [3:0]    sz;
    logic [3:0]    base;
    logic          size_ok;
    logic          fit;
    logic [7:0]    ones;
    logic [7:0]    new_bits;

    assign LDSn    = 1'b1;
    assign iter_nx = iter + 1'b1;

    // Allocation decision for the board currently offering itself
    always_comb begin
        sz      = 4'd0;
        size_ok = 1'b1;
        unique case (size_r)
            3'b000:  sz = 4'd8;
            3'b111:  sz = 4'd4;
            3'b110:  sz = 4'd2;
            3'b101:  sz = 4'd1;
            default: size_ok = 1'b0;
        endcase
        base = nf;
        if (sz == 4'd8)
            base = 4'd2;
        else if (sz == 4'd4 || sz == 4'd2)
            base = nf + {3'b000, nf[0]};
        fit = size_ok && is_mem_r
            && (sz != 4'd8 || nf == 4'd2)
            && ({1'b0, base} + {1'b0, sz} <= 5'd10);
    end

    always_comb begin
        ones = 8'h00;
        unique case (sz_r)
            4'd8:    ones = 8'hFF;
            4'd4:    ones = 8'h0F;
            4'd2:    ones = 8'h03;
            4'd1:    ones = 8'h01;
            default: ones = 8'h00;
        endcase
        new_bits = ones << (base_r - 4'd2);
    end

    // Bus-cycle engine: one state per CLK, strobes all registered
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            bst      <= B_IDLE;
            ADDR     <= '0;
            DBUS_OUT <= '0;
            DBUS_OE  <= 1'b0;
            ASn      <= 1'b1;
            UDSn     <= 1'b1;
            RWn      <= 1'b1;
            wr_cyc   <= 1'b0;
            wcnt     <= '0;
            rdata    <= '0;
            nack     <= 1'b0;
            bus_done <= 1'b0;
            dtack_q1 <= 1'b1;
            dtack_s  <= 1'b1;
        end else begin
            dtack_q1 <= DTACKn;
            dtack_s  <= dtack_q1;
            bus_done <= 1'b0;
            unique case (bst)
                B_IDLE: begin
                    if (req) begin
                        ADDR     <= req_addr;
                        RWn      <= ~req_wr;
                        DBUS_OE  <= req_wr;
                        DBUS_OUT <= req_data;
                        wr_cyc   <= req_wr;
                        bst      <= B_S0;
                    end
                end
                B_S0: begin
                    ASn  <= 1'b0;
                    UDSn <= wr_cyc;
                    bst  <= B_S2;
                end
                B_S2: begin
                    UDSn <= 1'b0;
                    bst  <= B_S4;
                end
                B_S4: begin
                    wcnt <= '0;
                    bst  <= B_WAIT;
                end
                B_WAIT: begin
                    if (!dtack_s) begin
                        if (!wr_cyc)
                            rdata <= DBUS_IN;
                        nack <= 1'b0;
                        ASn  <= 1'b1;
                        UDSn <= 1'b1;
                        bst  <= B_S7;
                    end else if (wcnt == W_LAST) begin
                        rdata <= 4'hF;
                        nack  <= 1'b1;
                        ASn   <= 1'b1;
                        UDSn  <= 1'b1;
                        bst   <= B_S7;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                B_S7: begin
                    DBUS_OE <= 1'b0;
                    RWn     <= 1'b1;
                    bst     <= B_S8;
                end
                B_S8: begin
                    bus_done <= 1'b1;
                    bst      <= B_IDLE;
                end
                default: bst <= B_IDLE;
            endcase
        end
    end

    // Enumeration sequencer; each access state issues one req and
    // waits for bus_done before moving on
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            est      <= E_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            CFGOUTn  <= 1'b1;
            mem_map  <= '0;
            boards   <= '0;
            nf       <= 4'd2;
            iter     <= '0;
            req      <= 1'b0;
            req_wr   <= 1'b0;
            req_addr <= '0;
            req_data <= '0;
            issued   <= 1'b0;
            gap      <= 1'b0;
            is_mem_r <= 1'b0;
            size_r   <= '0;
            base_r   <= '0;
            sz_r     <= '0;
        end else begin
            req  <= 1'b0;
            done <= 1'b0;
            unique case (est)
                E_IDLE: begin
                    if (start) begin
                        busy    <= 1'b1;
                        CFGOUTn <= 1'b0;
                        err     <= 1'b0;
                        mem_map <= '0;
                        boards  <= '0;
                        nf      <= 4'd2;
                        iter    <= '0;
                        issued  <= 1'b0;
                        est     <= E_RD_TYPE;
                    end
                end
                E_RD_TYPE: begin
                    if (!issued) begin
                        req      <= 1'b1;
                        req_wr   <= 1'b0;
                        req_addr <= A_TYPE;
                        issued   <= 1'b1;
                    end else if (bus_done) begin
                        issued   <= 1'b0;
                        is_mem_r <= rdata[1];
                        if (!nack && rdata[3:2] == 2'b11)
                            est <= E_RD_SIZE;
                        else
                            est <= E_DONE;
                    end
                end
                E_RD_SIZE: begin
                    if (!issued) begin
                        req      <= 1'b1;
                        req_wr   <= 1'b0;
                        req_addr <= A_SIZE;
                        issued   <= 1'b1;
                    end else if (bus_done) begin
                        issued <= 1'b0;
                        size_r <= rdata[2:0];
                        est    <= nack ? E_DONE : E_DECIDE;
                    end
                end
                E_DECIDE: begin
                    base_r <= base;
                    sz_r   <= sz;
                    est    <= fit ? E_WR_LO : E_SHUTUP;
                end
                E_WR_LO: begin
                    if (!issued) begin
                        req      <= 1'b1;
                        req_wr   <= 1'b1;
                        req_addr <= A_LO;
                        req_data <= 4'h0;
                        issued   <= 1'b1;
                    end else if (bus_done) begin
                        issued <= 1'b0;
                        est    <= E_WR_HI;
                    end
                end
                E_WR_HI: begin
                    if (!issued) begin
                        req      <= 1'b1;
                        req_wr   <= 1'b1;
                        req_addr <= A_HI;
                        req_data <= base_r;
                        issued   <= 1'b1;
                    end else if (bus_done) begin
                        issued  <= 1'b0;
                        mem_map <= mem_map | new_bits;
                        nf      <= base_r + sz_r;
                        boards  <= boards + 4'd1;
                        iter    <= iter_nx;
                        gap     <= 1'b0;
                        if (iter_nx == ITER_MAX) begin
                            err <= 1'b1;
                            est <= E_DONE;
                        end else begin
                            est <= E_GAP;
                        end
                    end
                end
                E_SHUTUP: begin
                    if (!issued) begin
                        req      <= 1'b1;
                        req_wr   <= 1'b1;
                        req_addr <= A_SHUT;
                        req_data <= 4'h0;
                        issued   <= 1'b1;
                    end else if (bus_done) begin
                        issued <= 1'b0;
                        iter   <= iter_nx;
                        gap    <= 1'b0;
                        if (iter_nx == ITER_MAX) begin
                            err <= 1'b1;
                            est <= E_DONE;
                        end else begin
                            est <= E_GAP;
                        end
                    end
                end
                E_GAP: begin
                    if (gap)
                        est <= E_RD_TYPE;
                    else
                        gap <= 1'b1;
                end
                E_DONE: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    CFGOUTn <= 1'b1;
                    est     <= E_IDLE;
                end
                default: est <= E_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_autoconfig_host.sv
// Bench for autoconfig_host: a scripted Autoconfig chain answers the bus
// and every config/shutup write is checked against an expected queue.
module tb_autoconfig_host;

    localparam int TIMEOUT  = 64;
    localparam int MAX_ITER = 16;

    localparam logic [22:0] A_TYPE = 23'h740000;
    localparam logic [22:0] A_SIZE = 23'h740001;
    localparam logic [22:0] A_HI   = 23'h740024;
    localparam logic [22:0] A_LO   = 23'h740025;
    localparam logic [22:0] A_SHUT = 23'h740026;

    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, err;
    logic [22:0] ADDR;
    logic [3:0]  DBUS_OUT, DBUS_IN;
    logic        DBUS_OE, ASn, UDSn, LDSn, RWn, DTACKn, CFGOUTn;
    logic [7:0]  mem_map;
    logic [3:0]  boards;

    always #5 CLK = ~CLK;

    autoconfig_host #(.TIMEOUT(TIMEOUT), .MAX_ITER(MAX_ITER)) dut (
        .CLK(CLK), .reset(reset), .start(start),
        .busy(busy), .done(done), .err(err),
        .ADDR(ADDR), .DBUS_OUT(DBUS_OUT), .DBUS_OE(DBUS_OE),
        .DBUS_IN(DBUS_IN), .ASn(ASn), .UDSn(UDSn), .LDSn(LDSn),
        .RWn(RWn), .DTACKn(DTACKn), .CFGOUTn(CFGOUTn),
        .mem_map(mem_map), .boards(boards)
    );

    // Chain model: offer idx is the board currently visible at $E80000
    logic [3:0]  o_typ [8];
    logic [3:0]  o_size[8];
    int          n_off = 0;
    bit          sticky = 1'b0;
    int          idx = 0;
    bit          wr_seen = 1'b0;
    logic [22:0] wa;
    logic [26:0] act_a[64];
    int          act_n = 0;
    logic        present;
    logic        is_cfg;

    assign present = (idx < n_off);
    assign is_cfg  = (ADDR[22:6] == 17'h1D000);
    assign DTACKn  = !(!ASn && !CFGOUTn && present && is_cfg);
    assign DBUS_IN = (ADDR == A_TYPE) ? o_typ[idx[2:0]] :
                     (ADDR == A_SIZE) ? o_size[idx[2:0]] : 4'hF;

    always @(posedge CLK) begin
        if (start && !busy) begin
            idx     = 0;
            act_n   = 0;
            wr_seen = 1'b0;
        end else if (!ASn && !UDSn && !RWn && DBUS_OE && !wr_seen) begin
            wr_seen = 1'b1;
            wa      = ADDR;
            if (act_n < 64)
                act_a[act_n] = {ADDR, DBUS_OUT};
            act_n++;
        end else if (ASn && wr_seen) begin
            wr_seen = 1'b0;
            if ((wa == A_HI || wa == A_SHUT) && !(sticky && idx == n_off - 1))
                idx++;
        end
    end

    logic [26:0] exp_q[$];
    int n_checks = 0;
    int n_pass = 0;

    task automatic run_enum(input int extra_at, output int cyc, output bit ok);
        @(negedge CLK) start = 1'b1;
        @(negedge CLK) start = 1'b0;
        cyc = 0;
        ok = 1'b0;
        while (cyc < 5000) begin
            @(negedge CLK);
            cyc++;
            start = (cyc == extra_at);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge CLK);
        n_checks++;
        if ({ASn, UDSn, LDSn, RWn, DBUS_OE, CFGOUTn, busy, done, err} !== 9'b111101000)
            $display("FAIL reset_ctl got %b need 111101000",
                     {ASn, UDSn, LDSn, RWn, DBUS_OE, CFGOUTn, busy, done, err});
        else n_pass++;
        n_checks++;
        if (ADDR !== 23'h0 || DBUS_OUT !== 4'h0)
            $display("FAIL reset_bus got %h/%h need 0/0", ADDR, DBUS_OUT);
        else n_pass++;
        n_checks++;
        if (mem_map !== 8'h00 || boards !== 4'h0)
            $display("FAIL reset_alloc got %h/%h need 00/0", mem_map, boards);
        else n_pass++;
        @(negedge CLK) reset = 1'b1;
        repeat (2) @(negedge CLK);
        n_checks++;
        if (busy !== 1'b0 || ASn !== 1'b1)
            $display("FAIL reset_idle got busy=%b ASn=%b need 0 1", busy, ASn);
        else n_pass++;
    endtask

    task automatic test_single_8mb;
        int cyc; bit ok; int k; logic [26:0] e, got;
        n_off = 1; sticky = 1'b0;
        o_typ[0] = 4'hE; o_size[0] = 4'h0;
        exp_q.delete();
        exp_q.push_back({A_LO, 4'h0});
        exp_q.push_back({A_HI, 4'h2});
        run_enum(0, cyc, ok);
        n_checks++;
        if (!ok) $display("FAIL single_done got timeout need done");
        else n_pass++;
        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = (k < act_n) ? act_a[k] : 27'h7FFFFFF;
            n_checks++;
            if (got !== e) $display("FAIL single_wr%0d got %h need %h", k, got, e);
            else n_pass++;
            k++;
        end
        n_checks++;
        if (act_n !== k) $display("FAIL single_nwr got %0d need %0d", act_n, k);
        else n_pass++;
        n_checks++;
        if (mem_map !== 8'hFF || boards !== 4'd1 || err !== 1'b0)
            $display("FAIL single_alloc got %h/%0d/%b need ff/1/0", mem_map, boards, err);
        else n_pass++;
        @(negedge CLK);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || CFGOUTn !== 1'b1)
            $display("FAIL single_pulse got %b%b%b need 001", done, busy, CFGOUTn);
        else n_pass++;
    endtask

    task automatic test_no_board;
        int cyc; bit ok;
        n_off = 0; sticky = 1'b0;
        run_enum(0, cyc, ok);
        n_checks++;
        if (!ok || cyc < TIMEOUT + 6 || cyc > TIMEOUT + 14)
            $display("FAIL noboard_time got %0d ok=%b need %0d..%0d",
                     cyc, ok, TIMEOUT + 6, TIMEOUT + 14);
        else n_pass++;
        n_checks++;
        if (act_n !== 0 || mem_map !== 8'h00 || boards !== 4'd0 || err !== 1'b0)
            $display("FAIL noboard_res got %0d/%h/%0d/%b need 0/00/0/0",
                     act_n, mem_map, boards, err);
        else n_pass++;
    endtask

    task automatic test_reoffer;
        int cyc; bit ok; int k; logic [26:0] e, got;
        n_off = 3; sticky = 1'b0;
        o_typ[0] = 4'hE; o_size[0] = 4'h7;
        o_typ[1] = 4'hE; o_size[1] = 4'h0;
        o_typ[2] = 4'hE; o_size[2] = 4'h7;
        exp_q.delete();
        exp_q.push_back({A_LO, 4'h0});
        exp_q.push_back({A_HI, 4'h2});
        exp_q.push_back({A_SHUT, 4'h0});
        exp_q.push_back({A_LO, 4'h0});
        exp_q.push_back({A_HI, 4'h6});
        run_enum(0, cyc, ok);
        n_checks++;
        if (!ok) $display("FAIL reoffer_done got timeout need done");
        else n_pass++;
        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = (k < act_n) ? act_a[k] : 27'h7FFFFFF;
            n_checks++;
            if (got !== e) $display("FAIL reoffer_wr%0d got %h need %h", k, got, e);
            else n_pass++;
            k++;
        end
        n_checks++;
        if (act_n !== k || mem_map !== 8'hFF || boards !== 4'd2)
            $display("FAIL reoffer_alloc got %0d/%h/%0d need %0d/ff/2",
                     act_n, mem_map, boards, k);
        else n_pass++;
    endtask

    task automatic test_mixed(input bit big_first);
        int cyc; bit ok; int k; logic [26:0] e, got;
        logic [7:0] need_map;
        n_off = 3; sticky = 1'b0;
        o_typ[0] = 4'hE; o_typ[1] = 4'hE; o_typ[2] = 4'hE;
        exp_q.delete();
        exp_q.push_back({A_LO, 4'h0});
        exp_q.push_back({A_HI, 4'h2});
        exp_q.push_back({A_LO, 4'h0});
        if (big_first) begin
            o_size[0] = 4'h7; o_size[1] = 4'h6; o_size[2] = 4'h5;
            exp_q.push_back({A_HI, 4'h6});
            exp_q.push_back({A_LO, 4'h0});
            exp_q.push_back({A_HI, 4'h8});
            need_map = 8'h7F;
        end else begin
            o_size[0] = 4'h6; o_size[1] = 4'h5; o_size[2] = 4'h7;
            exp_q.push_back({A_HI, 4'h4});
            exp_q.push_back({A_LO, 4'h0});
            exp_q.push_back({A_HI, 4'h6});
            need_map = 8'hF7;
        end
        run_enum(big_first ? 0 : 40, cyc, ok);
        n_checks++;
        if (!ok) $display("FAIL mixed%0d_done got timeout need done", big_first);
        else n_pass++;
        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = (k < act_n) ? act_a[k] : 27'h7FFFFFF;
            n_checks++;
            if (got !== e)
                $display("FAIL mixed%0d_wr%0d got %h need %h", big_first, k, got, e);
            else n_pass++;
            k++;
        end
        n_checks++;
        if (act_n !== k || mem_map !== need_map || boards !== 4'd3)
            $display("FAIL mixed%0d_alloc got %0d/%h/%0d need %0d/%h/3",
                     big_first, act_n, mem_map, boards, k, need_map);
        else n_pass++;
    endtask

    task automatic test_never_passes;
        int cyc; bit ok; int k; logic [26:0] e, got;
        n_off = 1; sticky = 1'b1;
        o_typ[0] = 4'hE; o_size[0] = 4'h0;
        exp_q.delete();
        exp_q.push_back({A_LO, 4'h0});
        exp_q.push_back({A_HI, 4'h2});
        for (int i = 1; i < MAX_ITER; i++)
            exp_q.push_back({A_SHUT, 4'h0});
        run_enum(0, cyc, ok);
        n_checks++;
        if (!ok) $display("FAIL stuck_done got timeout need done");
        else n_pass++;
        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = (k < act_n) ? act_a[k] : 27'h7FFFFFF;
            n_checks++;
            if (got !== e) $display("FAIL stuck_wr%0d got %h need %h", k, got, e);
            else n_pass++;
            k++;
        end
        n_checks++;
        if (act_n !== k || err !== 1'b1 || boards !== 4'd1 || mem_map !== 8'hFF)
            $display("FAIL stuck_err got %0d/%b/%0d/%h need %0d/1/1/ff",
                     act_n, err, boards, mem_map, k);
        else n_pass++;
        sticky = 1'b0;
    endtask

    task automatic test_non_memory;
        int cyc; bit ok; int k; logic [26:0] e, got;
        n_off = 1; sticky = 1'b0;
        o_typ[0] = 4'hC; o_size[0] = 4'h0;
        exp_q.delete();
        exp_q.push_back({A_SHUT, 4'h0});
        run_enum(0, cyc, ok);
        n_checks++;
        if (!ok) $display("FAIL nonmem_done got timeout need done");
        else n_pass++;
        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = (k < act_n) ? act_a[k] : 27'h7FFFFFF;
            n_checks++;
            if (got !== e) $display("FAIL nonmem_wr%0d got %h need %h", k, got, e);
            else n_pass++;
            k++;
        end
        n_checks++;
        if (act_n !== k || boards !== 4'd0 || mem_map !== 8'h00 || err !== 1'b0)
            $display("FAIL nonmem_alloc got %0d/%0d/%h/%b need %0d/0/00/0",
                     act_n, boards, mem_map, err, k);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        int n;
        n_off = 0; sticky = 1'b0;
        @(negedge CLK) start = 1'b1;
        @(negedge CLK) start = 1'b0;
        n = 0;
        while (ASn !== 1'b0 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        n_checks++;
        if (ASn !== 1'b0) $display("FAIL rstmid_as got ASn=%b need 0", ASn);
        else n_pass++;
        repeat (4) @(posedge CLK);
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (ASn !== 1'b1 || UDSn !== 1'b1 || busy !== 1'b0 || CFGOUTn !== 1'b1)
            $display("FAIL rstmid_strobe got %b%b%b%b need 1101",
                     ASn, UDSn, busy, CFGOUTn);
        else n_pass++;
        @(negedge CLK) reset = 1'b1;
        @(negedge CLK);
        test_single_8mb();
    endtask

    initial begin
        test_reset();
        test_single_8mb();
        test_no_board();
        test_reoffer();
        test_mixed(1'b0);
        test_mixed(1'b1);
        test_never_passes();
        test_non_memory();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
